// File: rtl/i2c_master_core.sv
// i2c_master_core: bit-level single-master I2C engine.
// Generates open-drain SCL/SDA for START/WR/RD/STOP/RESTART commands.
module i2c_master_core #(
    parameter int DATA_BITS  = 8,
    parameter int DVSR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [2:0]            cmd,
    input  logic                  cmd_valid,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  en_ack,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    output tri                    scl,
    inout  tri                    sda,
    output logic                  ready,
    output logic                  done_tick,
    output logic                  ack,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  bus_busy
);

    localparam int NB = DATA_BITS + 1;
    localparam int BW = $clog2(NB + 1);

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S1   = 4'd1;
    localparam logic [3:0] ST_S2   = 4'd2;
    localparam logic [3:0] ST_HOLD = 4'd3;
    localparam logic [3:0] ST_D1   = 4'd4;
    localparam logic [3:0] ST_D2   = 4'd5;
    localparam logic [3:0] ST_D3   = 4'd6;
    localparam logic [3:0] ST_D4   = 4'd7;
    localparam logic [3:0] ST_R1   = 4'd8;
    localparam logic [3:0] ST_R2   = 4'd9;
    localparam logic [3:0] ST_P1   = 4'd10;
    localparam logic [3:0] ST_P2   = 4'd11;
    localparam logic [3:0] ST_P3   = 4'd12;

    logic [3:0]            state, state_n;
    logic [DVSR_WIDTH-1:0] cnt, cnt_n;
    logic [DVSR_WIDTH-1:0] q, q_n;
    logic [DVSR_WIDTH-1:0] q_in;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [NB-1:0]         tx, tx_n;
    logic [NB-1:0]         rx, rx_n;
    logic                  is_rd, rd_n;
    logic                  scl_low, scl_low_n;
    logic                  sda_low, sda_low_n;
    logic                  done_n, ack_n, busy_n;
    logic [DATA_BITS-1:0]  dout_n;
    logic                  accept;
    logic                  step;
    logic                  sda_in;

    // Open-drain pads: only ever pull low, enables straight from flops.
    assign scl    = scl_low ? 1'b0 : 1'bz;
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign ready  = (state == ST_IDLE) || (state == ST_HOLD);
    assign accept = cmd_valid && ready;
    assign step   = (cnt == q - 1'b1);
    assign q_in   = (dvsr == '0) ? DVSR_WIDTH'(1) : dvsr;

    // Next-state, datapath and next line-drive computation.
    always_comb begin
        state_n = state;
        cnt_n   = step ? '0 : cnt + 1'b1;
        q_n     = q;
        bit_n   = bit_cnt;
        tx_n    = tx;
        rx_n    = rx;
        rd_n    = is_rd;
        done_n  = 1'b0;
        ack_n   = ack;
        dout_n  = dout;
        busy_n  = bus_busy;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (accept && cmd == CMD_START) begin
                    state_n = ST_S1;
                    q_n     = q_in;
                end
            end
            ST_HOLD: begin
                cnt_n = '0;
                if (accept) begin
                    case (cmd)
                        CMD_WR, CMD_RD: begin
                            state_n = ST_D1;
                            q_n     = q_in;
                            bit_n   = '0;
                            rd_n    = (cmd == CMD_RD);
                            if (cmd == CMD_RD)
                                tx_n = {{DATA_BITS{1'b1}}, ~en_ack};
                            else
                                tx_n = {din, 1'b1};
                        end
                        CMD_STOP: begin
                            state_n = ST_P1;
                            q_n     = q_in;
                        end
                        CMD_START, CMD_RESTART: begin
                            state_n = ST_R1;
                            q_n     = q_in;
                        end
                        default: ;
                    endcase
                end
            end
            ST_S1: if (step) state_n = ST_S2;
            ST_S2: begin
                if (step) begin
                    state_n = ST_HOLD;
                    done_n  = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ST_R1: if (step) state_n = ST_R2;
            ST_R2: if (step) state_n = ST_S2;
            ST_P1: if (step) state_n = ST_P2;
            ST_P2: if (step) state_n = ST_P3;
            ST_P3: begin
                if (step) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            ST_D1: if (step) state_n = ST_D2;
            ST_D2: begin
                if (step) begin
                    state_n = ST_D3;
                    rx_n    = {rx[NB-2:0], sda_in};
                end
            end
            ST_D3: if (step) state_n = ST_D4;
            ST_D4: begin
                if (step) begin
                    if (bit_cnt == BW'(NB - 1)) begin
                        state_n = ST_HOLD;
                        done_n  = 1'b1;
                        if (is_rd)
                            dout_n = rx[NB-1:1];
                        else
                            ack_n = ~rx[0];
                    end else begin
                        state_n = ST_D1;
                        bit_n   = bit_cnt + 1'b1;
                        tx_n    = {tx[NB-2:0], 1'b1};
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        scl_low_n = 1'b0;
        sda_low_n = 1'b0;
        case (state_n)
            ST_HOLD: begin
                scl_low_n = 1'b1;
                sda_low_n = sda_low;
            end
            ST_S2: sda_low_n = 1'b1;
            ST_D1: begin
                scl_low_n = 1'b1;
                sda_low_n = ~tx_n[NB-1];
            end
            ST_D2, ST_D3: sda_low_n = ~tx_n[NB-1];
            ST_D4: begin
                scl_low_n = 1'b1;
                sda_low_n = ~tx_n[NB-1];
            end
            ST_R1: scl_low_n = 1'b1;
            ST_P1: begin
                scl_low_n = 1'b1;
                sda_low_n = 1'b1;
            end
            ST_P2: sda_low_n = 1'b1;
            default: ;
        endcase
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            q         <= DVSR_WIDTH'(1);
            bit_cnt   <= '0;
            tx        <= '1;
            rx        <= '0;
            is_rd     <= 1'b0;
            scl_low   <= 1'b0;
            sda_low   <= 1'b0;
            done_tick <= 1'b0;
            ack       <= 1'b0;
            dout      <= '0;
            bus_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q         <= q_n;
            bit_cnt   <= bit_n;
            tx        <= tx_n;
            rx        <= rx_n;
            is_rd     <= rd_n;
            scl_low   <= scl_low_n;
            sda_low   <= sda_low_n;
            done_tick <= done_n;
            ack       <= ack_n;
            dout      <= dout_n;
            bus_busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: directed scoreboard bench for the I2C master engine.
// Includes a simple open-drain slave model and a line monitor.
module tb_i2c_master_core;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [7:0]  din;
    logic        en_ack;
    logic [15:0] dvsr;
    wire         scl;
    wire         sda;
    logic        ready;
    logic        done_tick;
    logic        ack;
    logic [7:0]  dout;
    logic        bus_busy;

    always #5 clk = ~clk;

    pullup (scl);
    pullup (sda);

    logic       slv_low;
    int         slv_mode = 0;
    logic [7:0] slv_byte = 8'h00;
    int         fall_cnt = 0;

    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_core #(.DATA_BITS(8), .DVSR_WIDTH(16)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .din       (din),
        .en_ack    (en_ack),
        .dvsr      (dvsr),
        .scl       (scl),
        .sda       (sda),
        .ready     (ready),
        .done_tick (done_tick),
        .ack       (ack),
        .dout      (dout),
        .bus_busy  (bus_busy)
    );

    // Slave: mode 1 ACKs the 9th bit, mode 2 drives slv_byte MSB first.
    always_comb begin
        slv_low = 1'b0;
        if (slv_mode == 1)
            slv_low = (fall_cnt == 8);
        else if (slv_mode == 2 && fall_cnt < 8)
            slv_low = !slv_byte[7 - fall_cnt];
    end

    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic obs_q[$];
    int   n_start = 0;
    int   n_stop  = 0;

    // Line monitor: SDA at SCL rise, SCL falls, START/STOP conditions.
    always @(posedge clk) begin
        if (!prev_scl && scl) obs_q.push_back(sda);
        if (prev_scl && !scl) fall_cnt++;
        if (prev_scl && scl && prev_sda && !sda) n_start++;
        if (prev_scl && scl && !prev_sda && sda) n_stop++;
        prev_scl = scl;
        prev_sda = sda;
    end

    typedef struct {
        string      tag;
        int         lat;
        logic       ack;
        logic [7:0] dout;
        logic       busy;
        int         dst;
        int         dsp;
        int         nbits;
        logic [8:0] bits;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] c,
                       input logic [7:0] d, input logic ea,
                       input logic [15:0] dv, input bit intrude,
                       input int lat, input logic eack,
                       input logic [7:0] edout, input logic ebusy,
                       input int dst, input int dsp, input int nbits,
                       input logic [8:0] bits);
        exp_t e;
        int   k;
        int   s0;
        int   p0;
        obs_q.delete();
        fall_cnt = 0;
        s0 = n_start;
        p0 = n_stop;
        @(negedge clk);
        cmd = c; din = d; en_ack = ea; dvsr = dv; cmd_valid = 1'b1;
        sb.push_back('{tag, lat, eack, edout, ebusy, dst, dsp, nbits, bits});
        @(negedge clk);
        k = 0;
        while (done_tick !== 1'b1 && k < 5000) begin
            if (intrude && k == 10) begin
                chk({tag, "_busy_ready"}, ready, 1'b0);
                cmd = 3'b011;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_lat"}, k, e.lat);
        chk({e.tag, "_ack"}, ack, e.ack);
        chk({e.tag, "_dout"}, dout, e.dout);
        chk({e.tag, "_busy"}, bus_busy, e.busy);
        chk({e.tag, "_ready"}, ready, 1'b1);
        chk({e.tag, "_nstart"}, n_start - s0, e.dst);
        chk({e.tag, "_nstop"}, n_stop - p0, e.dsp);
        if (e.nbits > 0) begin
            chk({e.tag, "_nbits"}, obs_q.size(), e.nbits);
            if (obs_q.size() == e.nbits)
                for (int i = 0; i < e.nbits; i++)
                    chk({e.tag, "_bit"}, obs_q[i], e.bits[8-i]);
        end
        @(negedge clk);
        chk({e.tag, "_pulse"}, done_tick, 1'b0);
    endtask

    // Issue a command that must be ignored and watch for any reaction.
    task automatic probe(input string tag, input logic [2:0] c);
        int   seen;
        int   moved;
        logic s0;
        logic d0;
        seen = 0;
        moved = 0;
        @(negedge clk);
        s0 = scl;
        d0 = sda;
        cmd = c; din = 8'hFF; dvsr = 16'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_tick) seen++;
            if (!ready) seen++;
            if (scl !== s0 || sda !== d0) moved++;
            @(negedge clk);
        end
        chk({tag, "_noreact"}, seen, 0);
        chk({tag, "_lines"}, moved, 0);
    endtask

    initial begin
        int k;
        arst_n = 1'b0;
        cmd = 3'b000;
        cmd_valid = 1'b0;
        din = 8'h00;
        en_ack = 1'b0;
        dvsr = 16'd4;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done_tick, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda", sda, 1'b1);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        probe("idle_wr", 3'b001);
        probe("idle_rd", 3'b010);
        probe("idle_stop", 3'b011);
        probe("idle_restart", 3'b100);
        probe("idle_rsvd", 3'b111);

        run("start", 3'b000, 8'h00, 1'b0, 16'd4, 1'b0,
            8, 1'b0, 8'h00, 1'b1, 1, 0, 0, 9'h000);
        slv_mode = 1;
        run("wr_ack", 3'b001, 8'hA5, 1'b0, 16'd4, 1'b1,
            144, 1'b1, 8'h00, 1'b1, 0, 0, 9, {8'hA5, 1'b0});
        slv_mode = 0;
        run("wr_nack", 3'b001, 8'hA5, 1'b0, 16'd2, 1'b0,
            72, 1'b0, 8'h00, 1'b1, 0, 0, 9, {8'hA5, 1'b1});
        slv_mode = 2;
        slv_byte = 8'h3C;
        run("rd_ack", 3'b010, 8'h00, 1'b1, 16'd3, 1'b0,
            108, 1'b0, 8'h3C, 1'b1, 0, 0, 9, {8'h3C, 1'b0});
        slv_byte = 8'hC3;
        run("rd_nack", 3'b010, 8'h00, 1'b0, 16'd1, 1'b0,
            36, 1'b0, 8'hC3, 1'b1, 0, 0, 9, {8'hC3, 1'b1});
        slv_mode = 0;
        probe("hold_rsvd", 3'b111);
        run("stop", 3'b011, 8'h00, 1'b0, 16'd2, 1'b0,
            6, 1'b0, 8'hC3, 1'b0, 0, 1, 0, 9'h000);

        run("start2", 3'b000, 8'h00, 1'b0, 16'd2, 1'b0,
            4, 1'b0, 8'hC3, 1'b1, 1, 0, 0, 9'h000);
        run("restart", 3'b100, 8'h00, 1'b0, 16'd2, 1'b0,
            6, 1'b0, 8'hC3, 1'b1, 1, 0, 0, 9'h000);
        run("start_hold", 3'b000, 8'h00, 1'b0, 16'd1, 1'b0,
            3, 1'b0, 8'hC3, 1'b1, 1, 0, 0, 9'h000);
        slv_mode = 1;
        run("wr_ack2", 3'b001, 8'h5A, 1'b0, 16'd1, 1'b0,
            36, 1'b1, 8'hC3, 1'b1, 0, 0, 9, {8'h5A, 1'b0});
        slv_mode = 0;

        obs_q.delete();
        fall_cnt = 0;
        @(negedge clk);
        cmd = 3'b001; din = 8'hA5; dvsr = 16'd4; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (obs_q.size() < 5 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("mid_reach_bit4", k < 2000, 1'b1);
        #2;
        chk("mid_busy_before", ready, 1'b0);
        arst_n = 1'b0;
        #1;
        chk("mid_scl", scl, 1'b1);
        chk("mid_sda", sda, 1'b1);
        chk("mid_ready", ready, 1'b1);
        chk("mid_done", done_tick, 1'b0);
        chk("mid_ack", ack, 1'b0);
        chk("mid_dout", dout, 8'h00);
        chk("mid_busy", bus_busy, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        run("start_q0", 3'b000, 8'h00, 1'b0, 16'd0, 1'b0,
            2, 1'b0, 8'h00, 1'b1, 1, 0, 0, 9'h000);
        run("stop_q0", 3'b011, 8'h00, 1'b0, 16'd0, 1'b0,
            3, 1'b0, 8'h00, 1'b0, 0, 1, 0, 9'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
- Bit-level I2C master engine. It is the downstream stage of the I2C MMIO peripheral.
- It accepts one bus command at a time from the peripheral's control/FIFO logic and generates open-drain SCL/SDA waveforms.
- On WR it shifts out the supplied byte; on RD it shifts in a byte. It reports completion, slave ACK and read data back upstream.
- Single master only. No clock stretching, no arbitration.

Parameters:
DATA_BITS, 8, bits per transfer before the ACK bit
DVSR_WIDTH, 16, width of the quarter-period divisor

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
cmd  input  3  command: 000 START, 001 WR, 010 RD, 011 STOP, 100 RESTART; other codes reserved
cmd_valid  input  1  one-cycle strobe; accepts cmd/din/en_ack/dvsr when ready=1
din  input  DATA_BITS  byte to transmit on WR (address byte = {addr7, rw})
en_ack  input  1  RD only: 1 = master drives ACK (SDA low) on 9th bit; 0 = NACK (released)
dvsr  input  DVSR_WIDTH  quarter SCL period in clk cycles; Q = max(dvsr,1)
scl  output  1 (tri)  open-drain clock: drives 0 or Z
sda  inout  1 (tri)  open-drain data: drives 0 or Z; sampled as input
ready  output  1  engine can accept a command
done_tick  output  1  one-cycle pulse when an accepted command completes
ack  output  1  1 = slave acknowledged the last WR (SDA low on 9th bit)
dout  output  DATA_BITS  byte received by the last RD
bus_busy  output  1  high from START completion until STOP completion

Behaviour:
- Reset (async, any time including mid-transfer):
  - scl and sda released (Z); state IDLE.
  - ready=1, done_tick=0, ack=0, dout=0, bus_busy=0.
- scl/sda drive-low enables come straight from registers (glitch-free). dvsr is latched at acceptance and held for the whole command.
- Acceptance:
  - cmd_valid && ready latches inputs; ready drops the next cycle.
  - cmd_valid while ready=0 is ignored.
  - Reserved codes are ignored: no done_tick.
- States:
  - IDLE: lines released, ready=1, bus_busy=0.
    - START goes to S1.
    - WR/RD/STOP/RESTART in IDLE are ignored (no done_tick, ready stays 1).
  - S1: scl Z, sda Z, for Q cycles.
  - S2: scl Z, sda 0, for Q cycles → HOLD.
  - HOLD: scl 0, sda held at last value, ready=1, bus_busy=1.
    - WR/RD go to D1 for bit 0.
    - STOP goes to P1.
    - RESTART goes to R1.
    - START in HOLD is treated as RESTART.
  - D1..D4, Q cycles each, repeated for DATA_BITS+1 bits, MSB first:
    - D1: scl 0; sda set to the bit value.
    - D2: scl Z.
    - D3: scl Z; sda sampled on the D2→D3 transition.
    - D4: scl 0.
    - WR: data bits come from din; the 9th bit is released and its sampled value drives ack = ~sda.
    - RD: data bits are released and sampled into a shift register; the 9th bit is driven 0 if en_ack, else released. dout updates at completion.
    - After the 9th D4 → HOLD.
  - R1: scl 0, sda Z, Q cycles. R2: scl Z, sda Z, Q cycles → S2.
  - P1: scl 0, sda 0. P2: scl Z, sda 0. P3: scl Z, sda Z. Q cycles each → IDLE.
- Latency from the accepting edge to the done_tick cycle:
  - START: 2Q.
  - RESTART: 3Q.
  - WR/RD: 4Q·(DATA_BITS+1) = 36Q.
  - STOP: 3Q.
- done_tick is asserted in the first cycle of HOLD/IDLE after completion. ready rises in that same cycle, so a back-to-back cmd_valid in that cycle is accepted.
- ack holds its value until the next WR completes. dout holds its value until the next RD completes.
- bus_busy rises with START/RESTART done_tick and falls with STOP done_tick.
- Every SDA change during data bits occurs only while SCL is low (D1). SDA changes with SCL high occur only in S2 (START) and P3 (STOP).

Test Plan:
- Reset, dvsr=4, START → scl/sda stay Z for 4 cycles; sda falls while scl Z; done_tick exactly 8 cycles after acceptance; bus_busy=1, ready=1.
- After START, WR din=8'hA5, bench slave pulls sda low on 9th bit → SDA at each SCL rise = 1,0,1,0,0,1,0,1; ack=1; done_tick 144 cycles after acceptance. Repeat with no slave ACK → ack=0.
- RD with slave driving 8'h3C, en_ack=1 → dout=8'h3C; master holds sda low during the 9th SCL high. With en_ack=0 → sda Z on the 9th bit.
- STOP from HOLD, dvsr=2 → sda rises while scl Z; done_tick 6 cycles after acceptance; bus_busy=0. Then RESTART → START condition with no STOP in between, done_tick 3Q after acceptance.
- WR/RD/STOP issued in IDLE, cmd_valid during a transfer, and cmd=3'b111 → no done_tick, no line activity, transfer in progress unaffected.
- arst_n asserted mid-WR (bit 4, D2) → scl/sda Z immediately; all outputs at reset values; next START runs normally. dvsr=0 → behaves as Q=1 (START done_tick after 2 cycles).
